// File: rtl/roi_scheduler.sv
// roi_scheduler: buffers lidar cluster boxes, issues them one at a time to project2image,
// and reports the peak CarDetection confidence (or a timeout) for each cluster.
module roi_scheduler #(
    parameter int          DEPTH   = 4,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [15:0] min_x_in,
    input  logic [15:0] min_y_in,
    input  logic [15:0] min_z_in,
    input  logic [15:0] max_x_in,
    input  logic [15:0] max_y_in,
    input  logic [15:0] max_z_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] min_x,
    output logic [15:0] min_y,
    output logic [15:0] min_z,
    output logic [15:0] max_x,
    output logic [15:0] max_y,
    output logic [15:0] max_z,
    input  logic [43:0] det_conf,
    input  logic        det_conf_valid,
    input  logic        det_done,
    output logic        res_valid,
    output logic [7:0]  res_id,
    output logic [43:0] res_conf,
    output logic        res_car,
    output logic        res_timeout,
    output logic        busy
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [23:0] T_LAST   = TIMEOUT - 24'd1;
    localparam logic [43:0] CONF_MIN = 44'h800_0000_0000;
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  ISSUE    = 2'd1;
    localparam logic [1:0]  WAIT_DET = 2'd2;
    localparam logic [1:0]  REPORT   = 2'd3;

    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [95:0]   r_coord;
    logic          r_valid_out;
    logic [23:0]   r_timer;
    logic [43:0]   r_max;
    logic          r_seen;
    logic [7:0]    r_id_cnt;
    logic          r_res_valid, r_res_car, r_res_timeout;
    logic [7:0]    r_res_id;
    logic [43:0]   r_res_conf;
    logic          w_push, w_pop, w_fold, w_seen_next, w_close;
    logic [43:0]   w_max_next;

    assign ready_out = r_count != FULL;
    assign w_push    = valid_in && ready_out;
    assign w_pop     = r_valid_out && ready_in;
    // a confidence arriving with det_done is folded in before the result is latched
    assign w_fold      = (r_state == WAIT_DET) && det_conf_valid;
    assign w_max_next  = (w_fold && $signed(det_conf) > $signed(r_max)) ? det_conf : r_max;
    assign w_seen_next = r_seen || w_fold;
    assign w_close     = (r_state == WAIT_DET) && (det_done || r_timer == T_LAST);

    assign valid_out = r_valid_out;
    assign {min_x, min_y, min_z, max_x, max_y, max_z} = r_coord;
    assign res_valid   = r_res_valid;
    assign res_id      = r_res_id;
    assign res_conf    = r_res_conf;
    assign res_car     = r_res_car;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_state != IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {min_x_in, min_y_in, min_z_in, max_x_in, max_y_in, max_z_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_coord       <= '0;
            r_valid_out   <= 1'b0;
            r_timer       <= '0;
            r_max         <= CONF_MIN;
            r_seen        <= 1'b0;
            r_id_cnt      <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_conf    <= '0;
            r_res_car     <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (r_count != '0) begin
                    r_state     <= ISSUE;
                    r_valid_out <= 1'b1;
                    r_coord     <= r_mem[r_rptr];
                end
                ISSUE: if (ready_in) begin
                    r_state     <= WAIT_DET;
                    r_valid_out <= 1'b0;
                    r_max       <= CONF_MIN;
                    r_timer     <= '0;
                    r_seen      <= 1'b0;
                end
                WAIT_DET: begin
                    r_timer <= r_timer + 24'd1;
                    r_max   <= w_max_next;
                    r_seen  <= w_seen_next;
                    if (w_close) begin
                        r_state       <= REPORT;
                        r_res_valid   <= 1'b1;
                        r_res_id      <= r_id_cnt;
                        r_res_conf    <= w_seen_next ? w_max_next : '0;
                        r_res_car     <= w_seen_next && $signed(w_max_next) > $signed(44'd0);
                        r_res_timeout <= !det_done;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_id_cnt    <= r_id_cnt + 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_roi_scheduler.sv
// tb_roi_scheduler: directed stimulus with a queue-based scoreboard for issued boxes
// and per-cluster results, checked by an independent monitor.
module tb_roi_scheduler;
    typedef struct packed {
        logic [7:0]  id;
        logic [43:0] conf;
        logic        car;
        logic        tmo;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] min_x_in = '0, min_y_in = '0, min_z_in = '0;
    logic [15:0] max_x_in = '0, max_y_in = '0, max_z_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
    logic [43:0] det_conf = '0;
    logic        det_conf_valid = 1'b0;
    logic        det_done = 1'b0;
    logic        res_valid;
    logic [7:0]  res_id;
    logic [43:0] res_conf;
    logic        res_car, res_timeout, busy;

    logic [95:0] crd_out;
    logic [95:0] q_crd[$];
    res_t        q_res[$];
    res_t        mon_e;
    logic [95:0] mon_c;
    logic [7:0]  next_id = '0;
    logic [7:0]  last_id = '0;
    int          n_res = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    assign crd_out = {min_x, min_y, min_z, max_x, max_y, max_z};

    roi_scheduler #(.DEPTH(4), .TIMEOUT(24'd16)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
        .min_x_in(min_x_in), .min_y_in(min_y_in), .min_z_in(min_z_in),
        .max_x_in(max_x_in), .max_y_in(max_y_in), .max_z_in(max_z_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .min_x(min_x), .min_y(min_y), .min_z(min_z), .max_x(max_x), .max_y(max_y), .max_z(max_z),
        .det_conf(det_conf), .det_conf_valid(det_conf_valid), .det_done(det_done),
        .res_valid(res_valid), .res_id(res_id), .res_conf(res_conf), .res_car(res_car),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [95:0] c);
        bit acc = 0;
        {min_x_in, min_y_in, min_z_in, max_x_in, max_y_in, max_z_in} = c;
        valid_in = 1'b1;
        for (int k = 0; k < 400 && !acc; k++) begin
            @(negedge clk);
            acc = ready_out;
            tick();
        end
        valid_in = 1'b0;
        if (acc) q_crd.push_back(c);
        else chk("push_accept", 96'(acc), 96'd1);
    endtask

    task automatic wait_issue();
        for (int k = 0; k < 400 && !valid_out; k++) tick();
        if (!valid_out) chk("issue_wait", 96'(valid_out), 96'd1);
        tick();
    endtask

    task automatic pulse(input logic [43:0] v);
        det_conf = v;
        det_conf_valid = 1'b1;
        tick();
        det_conf_valid = 1'b0;
    endtask

    task automatic done();
        det_done = 1'b1;
        tick();
        det_done = 1'b0;
        chk("done_latency", 96'(res_valid), 96'd1);
    endtask

    task automatic exp_res(input logic [43:0] conf, input logic car, input logic tmo);
        q_res.push_back('{id: next_id, conf: conf, car: car, tmo: tmo});
        next_id = next_id + 8'd1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_out"}, 96'(ready_out), 96'd1);
        chk({tag, "_valid_out"}, 96'(valid_out), 96'd0);
        chk({tag, "_coords"}, crd_out, 96'd0);
        chk({tag, "_res"}, 96'({res_valid, res_id, res_conf, res_car, res_timeout}), 96'd0);
        chk({tag, "_busy"}, 96'(busy), 96'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && valid_out && ready_in) begin
            if (q_crd.size() == 0) chk("unexpected_issue", 96'(valid_out), 96'd0);
            else begin
                mon_c = q_crd.pop_front();
                chk("issue_coords", crd_out, mon_c);
            end
        end
        if (reset_n && res_valid) begin
            n_res++;
            last_id = res_id;
            if (q_res.size() == 0) chk("unexpected_result", 96'(res_valid), 96'd0);
            else begin
                mon_e = q_res.pop_front();
                chk("res_id", 96'(res_id), 96'(mon_e.id));
                chk("res_conf", 96'(res_conf), 96'(mon_e.conf));
                chk("res_car", 96'(res_car), 96'(mon_e.car));
                chk("res_timeout", 96'(res_timeout), 96'(mon_e.tmo));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [95:0] ca;
        #2;
        chk_reset_outputs("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // detected cluster, 2-cycle push-to-issue latency
        exp_res(44'h1234, 1'b1, 1'b0);
        push({16'h0ff4, 16'h074b, 16'hfe43, 16'h12de, 16'h095c, 16'hffc5});
        chk("latency_1", 96'(valid_out), 96'd0);
        tick();
        chk("latency_2", 96'(valid_out), 96'd1);
        wait_issue();
        pulse(44'hFFF_FFFF_FFFB);
        pulse(44'h000_0000_1234);
        pulse(44'h000_0000_0007);
        done();
        tick();

        // negative-only confidence
        exp_res(44'hFFF_FFFF_FFFF, 1'b0, 1'b0);
        push({16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006});
        wait_issue();
        pulse(44'hFFFC3C55080);
        pulse(44'hFFF_FFFF_FFFF);
        done();
        tick();

        // timeout with no pulses: result 17 cycles after the handshake cycle
        exp_res(44'h0, 1'b0, 1'b1);
        push({16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666});
        wait_issue();
        for (k = 1; k < 40; k++) begin
            tick();
            if (res_valid) break;
        end
        chk("timeout_cycles", 96'(k), 96'd16);
        tick();

        // simultaneous confidence and done
        exp_res(44'h50, 1'b1, 1'b0);
        push({16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d, 16'h0e0e, 16'h0f0f});
        wait_issue();
        det_conf = 44'h50;
        det_conf_valid = 1'b1;
        done();
        det_conf_valid = 1'b0;
        tick();
        tick();

        // FIFO full with backpressure, then release
        ready_in = 1'b0;
        ca = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        for (int i = 0; i < 5; i++) exp_res(44'h0, 1'b0, 1'b1);
        push(ca);
        push({16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006});
        push({16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006});
        push({16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006});
        chk("full_ready_out", 96'(ready_out), 96'd0);
        {min_x_in, min_y_in, min_z_in, max_x_in, max_y_in, max_z_in} = {6{16'hEEEE}};
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ready_out", 96'(ready_out), 96'd0);
            chk("hold_valid_out", 96'(valid_out), 96'd1);
            chk("hold_coords", crd_out, ca);
        end
        ready_in = 1'b1;
        push({6{16'hEEEE}});
        for (k = 0; k < 400 && busy; k++) tick();
        chk("drain_busy", 96'(busy), 96'd0);
        chk("drain_results", 96'(q_res.size()), 96'd0);

        // id wrap: the 257th result carries id 0
        while (n_res < 257) begin
            exp_res(44'h77, 1'b1, 1'b0);
            push({16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'(n_res)});
            wait_issue();
            pulse(44'h77);
            done();
            tick();
        end
        chk("wrap_count", 96'(n_res), 96'd257);
        chk("wrap_id", 96'(last_id), 96'd0);

        // reset during WAIT_DET with two clusters queued
        push({16'h5101, 16'h5102, 16'h5103, 16'h5104, 16'h5105, 16'h5106});
        wait_issue();
        push({16'h5201, 16'h5202, 16'h5203, 16'h5204, 16'h5205, 16'h5206});
        push({16'h5301, 16'h5302, 16'h5303, 16'h5304, 16'h5305, 16'h5306});
        pulse(44'h99);
        reset_n = 1'b0;
        #1;
        q_crd.delete();
        chk_reset_outputs("midreset");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_reset_busy", 96'(busy), 96'd0);
            chk("post_reset_valid_out", 96'(valid_out), 96'd0);
        end
        chk("post_reset_results", 96'(n_res), 96'd257);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/roi_scheduler.md
# roi_scheduler

Sequences lidar cluster bounding boxes through the camera detection chain: project2image, image_in_ROI, imresize, CarDetection. Buffers up to DEPTH clusters and issues them one at a time on project2image's valid/ready input. For each cluster it collects CarDetection confidence pulses until `done` or a timeout, then reports one tagged result per cluster. Sits between the lidar clustering front end and project2image, with CarDetection status fed back.

## Interface
- DEPTH, 4: cluster FIFO entries; power of two, 2..16.
- TIMEOUT, 24'd1000000: cycles allowed per cluster from issue handshake to `det_done`.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  cluster offered by the front end.
- ready_out  out  1  FIFO not full.
- min_x_in, min_y_in, min_z_in, max_x_in, max_y_in, max_z_in  in  16 each  cluster box, s7c8f metres.
- valid_out  out  1  cluster presented to project2image.
- ready_in  in  1  project2image accepts.
- min_x, min_y, min_z, max_x, max_y, max_z  out  16 each  coordinates of the issued cluster.
- det_conf  in  44  CarDetection `confidence_out`, signed.
- det_conf_valid  in  1  CarDetection `confidence_valid_out`.
- det_done  in  1  CarDetection `done`, one-cycle pulse.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  8  sequence tag of the cluster.
- res_conf  out  44  maximum signed confidence seen for the cluster.
- res_car  out  1  res_conf > bias_zero, i.e. strictly positive.
- res_timeout  out  1  result closed by timeout, not `det_done`.
- busy  out  1  state ≠ IDLE or FIFO not empty.

## Operation
- **FIFO**
  - DEPTH × 96-bit storage; push on `valid_in && ready_out`; `ready_out = (count != DEPTH)`.
  - Pop happens only on the issue handshake.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves count unchanged. A push when full is ignored; it cannot occur because `ready_out` is low.
- **FSM states: IDLE, ISSUE, WAIT_DET, REPORT.**
  - IDLE: if FIFO not empty, go to ISSUE next cycle.
  - ISSUE: `valid_out = 1`, outputs driven from the FIFO head; they stay stable until the handshake.
  - ISSUE, on `valid_out && ready_in`: pop, clear `max_conf` to the most negative 44-bit value (44'h800_0000_0000), clear the timer, set `seen = 0`, go to WAIT_DET.
  - WAIT_DET, per `det_conf_valid`: `seen <= 1`; `max_conf <= max(max_conf, det_conf)` with a signed compare.
  - WAIT_DET: timer increments every cycle.
  - WAIT_DET, on `det_done`: go to REPORT with `timeout_flag = 0`.
  - WAIT_DET, on timer == TIMEOUT−1 without `det_done`: go to REPORT with `timeout_flag = 1`.
  - WAIT_DET: `det_done` and `det_conf_valid` in the same cycle means the confidence is folded in first, then the transition.
  - REPORT: `res_valid = 1` for one cycle. Then return to IDLE, and `id_cnt` increments (8-bit, wraps 255→0).
- **Result fields**
  - `res_id = id_cnt`.
  - `res_conf = seen ? max_conf : 0`.
  - `res_car = seen && max_conf > 0`.
  - `res_timeout = timeout_flag`.
- `det_done` or `det_conf_valid` outside WAIT_DET is ignored.
- Reset asserted mid-operation: FIFO is flushed; the in-flight cluster is dropped with no result.

## Timing
- Reset values: `ready_out = 1`, `valid_out = 0`, all coordinate outputs 0, `res_valid = 0`, `res_id = 0`, `res_conf = 0`, `res_car = 0`, `res_timeout = 0`, `busy = 0`, `id_cnt = 0`, state IDLE.
- Push to `valid_out` high: 2 cycles when idle (FIFO write, then IDLE→ISSUE).
- `det_done` to `res_valid`: 1 cycle (registered).
- Result outputs hold their values after the strobe until the next REPORT.
- Back-to-back clusters: minimum 2 cycles from `res_valid` to the next `valid_out` (REPORT→IDLE→ISSUE).
- Timeout: `res_valid` asserts exactly TIMEOUT+1 cycles after the issue handshake cycle.
- `valid_out` and the coordinate outputs are registered, with no combinational path from `ready_in`.
- `ready_out` depends only on the registered count.

## Test plan
- **Single cluster, detected.** Push min = (0x0ff4, 0x074b, 0xfe43), max = (0x12de, 0x095c, 0xffc5) with `ready_in = 1`. Then drive conf pulses −5, 0x1234, 7, followed by `det_done`. Required response: coordinates appear on the outputs exactly; one `res_valid` with `res_id = 0`, `res_conf = 0x1234`, `res_car = 1`, `res_timeout = 0`.
- **Negative-only confidence.** Conf pulses 44'hFFFC3C55080 and −1, then `det_done`. Required response: `res_conf = −1`, `res_car = 0`.
- **Timeout with no pulses.** TIMEOUT = 16; after issue, never drive `det_done`. Required response: `res_valid` 17 cycles after the handshake with `res_timeout = 1`, `res_conf = 0`, `res_car = 0`.
- **FIFO full and backpressure.** DEPTH = 4; push 5 clusters while `ready_in = 0`. Required response: `ready_out` drops after 4 accepted; `valid_out` coordinates stay stable.
  - Then release: results follow with ids 0..3 in push order; the fifth cluster is accepted once a slot frees.
- **Simultaneous events.** `det_conf_valid` with 0x50 in the same cycle as `det_done`. Required response: `res_conf = 0x50`.
- **Id wrap and reset.**
  - Run 257 clusters. Required response: the 257th result has `res_id = 0`.
  - Assert `reset_n = 0` during WAIT_DET with 2 clusters queued. Required response: all outputs return to their reset values; no `res_valid` appears; `busy = 0`.
